formula_1_res_buffer: RTL and testbench

// - Downstream stage of the pipelined formula_1 datapath (isqrt(a)+isqrt(b)+isqrt(c)).
// - That datapath has fixed latency and no backpressure. This block adds the missing flow control:
//   - A credit counter gates issue of new arguments.
//   - A FIFO absorbs results that arrive while the consumer stalls.
//   - The consumer sees a ready/valid stream.
// - Results are never dropped if upstream obeys up_rdy.

---
 rtl/formula_pipe_pkg.sv | 17 +
 rtl/formula_fifo_mem.sv | 33 +++
 rtl/formula_1_res_buffer.sv | 138 +++++++++++++
 tb/tb_formula_1_res_buffer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/formula_pipe_pkg.sv
// Shared definitions for the formula_1 result buffer.
// Holds the result width, the error-bit indices and the count-width helper.
package formula_pipe_pkg;

    localparam int unsigned RES_W        = 32;

    // Bit positions inside the sticky err vector
    localparam int unsigned ERR_CREDIT   = 0;
    localparam int unsigned ERR_SPURIOUS = 1;
    localparam int unsigned ERR_W        = 2;

    // Occupancy counters must represent 0..depth inclusive
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : formula_pipe_pkg

// File: rtl/formula_fifo_mem.sv
// Storage array for the result FIFO: DEPTH x W flops, one synchronous write
// port and one asynchronous read port. The contents are not reset.
//   clk    in  clock, rising edge
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (combinational from raddr)
module formula_fifo_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Write port; no reset so the array can map onto plain flops
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // First-word fall-through read
    assign rdata = mem_q[raddr];

endmodule : formula_fifo_mem

// File: rtl/formula_1_res_buffer.sv
// Flow-control stage behind the fixed-latency formula_1 pipe.
// Tracks issued-but-unreturned results with a credit counter so that
// every returning result is guaranteed a FIFO slot, and presents the
// buffered results as a ready/valid stream.
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active low
//   up_rdy    out  upstream may issue this cycle (registers only)
//   issue_vld in   an argument entered the formula pipe this cycle
//   res_vld   in   formula pipe result valid
//   res       in   formula pipe result data
//   out_vld   out  FIFO head valid
//   out_data  out  FIFO head data
//   out_rdy   in   consumer takes the head this cycle
//   count     out  entries stored
//   err       out  sticky protocol errors: [0] credit breach, [1] spurious result
module formula_1_res_buffer
    import formula_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = RES_W
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        up_rdy,
    input  logic                        issue_vld,
    input  logic                        res_vld,
    input  logic [W-1:0]                res,
    output logic                        out_vld,
    output logic [W-1:0]                out_data,
    input  logic                        out_rdy,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic [ERR_W-1:0]            err
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = CW + 1;

    // Pointer arithmetic relies on natural wrap of an AW-bit counter
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $fatal(1, "formula_1_res_buffer: DEPTH must be a power of two and >= 2");
    end

    logic [CW-1:0]    count_q,    count_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [ERR_W-1:0] err_q,      err_d;

    logic             full_c;
    logic             pop_c;
    logic             push_c;
    logic [SW-1:0]    occ_c;

    // Status derived purely from registers
    assign full_c  = (count_q == CW'(DEPTH));
    assign out_vld = (count_q != '0);
    assign pop_c   = out_vld & out_rdy;
    // A push into a full FIFO is only taken if the head leaves in the same cycle
    assign push_c  = res_vld & (~full_c | pop_c);

    // Credits: stored entries plus results still inside the formula pipe
    assign occ_c   = SW'(count_q) + SW'(inflight_q);
    assign up_rdy  = (occ_c < SW'(DEPTH));

    assign count   = count_q;
    assign err     = err_q;

    // Next-state logic for counters, pointers and sticky errors
    always_comb begin
        count_d    = count_q;
        inflight_d = inflight_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        err_d      = err_q;

        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        // Issue and return in the same cycle cancel; saturate at both ends
        if (issue_vld && !res_vld) begin
            if (inflight_q != '1) begin
                inflight_d = inflight_q + CW'(1);
            end
        end else if (res_vld && !issue_vld) begin
            if (inflight_q != '0) begin
                inflight_d = inflight_q - CW'(1);
            end
        end

        if (issue_vld && !up_rdy) begin
            err_d[ERR_CREDIT] = 1'b1;
        end
        if (res_vld && (inflight_q == '0) && !issue_vld) begin
            err_d[ERR_SPURIOUS] = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= '0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

    formula_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_mem (
        .clk   (clk),
        .we    (push_c),
        .waddr (wr_ptr_q),
        .wdata (res),
        .raddr (rd_ptr_q),
        .rdata (out_data)
    );

endmodule : formula_1_res_buffer

// File: tb/tb_formula_1_res_buffer.sv
// Scoreboard bench for formula_1_res_buffer. A behavioural formula pipe
// (fixed latency queue) drives results; the expected FIFO content is a
// queue of accepted results and a monitor compares the DUT against it.
module tb_formula_1_res_buffer;
    import formula_pipe_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned W     = RES_W;
    localparam int unsigned CW    = cnt_width(DEPTH);
    localparam int unsigned L     = 3;

    typedef struct packed {
        logic         vld;
        logic [W-1:0] d;
    } pipe_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          up_rdy;
    logic          issue_vld = 1'b0;
    logic          res_vld = 1'b0;
    logic [W-1:0]  res = '0;
    logic          out_vld;
    logic [W-1:0]  out_data;
    logic          out_rdy = 1'b0;
    logic [CW-1:0] count;
    logic [1:0]    err;

    logic [W-1:0]  exp_q[$];
    pipe_t         pipe[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            chk_en = 1'b0;
    bit            model_up = 1'b1;
    logic [1:0]    m_err = '0;
    logic [1:0]    pend_err = '0;
    bit            prev_rv = 1'b0;
    logic [W-1:0]  prev_r = '0;

    formula_1_res_buffer #(.DEPTH(DEPTH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_rdy    (up_rdy),
        .issue_vld (issue_vld),
        .res_vld   (res_vld),
        .res       (res),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .out_rdy   (out_rdy),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int pipe_busy();
        int n = 0;
        foreach (pipe[i]) if (pipe[i].vld) n++;
        return n;
    endfunction

    // Monitor: state checks against the model, then head compare and pop
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", W'(count), W'(exp_q.size()));
            chk("out_vld", W'(out_vld), W'(exp_q.size() != 0));
            chk("up_rdy", W'(up_rdy), W'(model_up));
            chk("err", W'(err), W'(m_err));
            if (out_vld && exp_q.size() != 0) begin
                chk("out_data", out_data, exp_q[0]);
                if (out_rdy) void'(exp_q.pop_front());
            end
        end
    end

    // One clock cycle of stimulus; model state is advanced for the edge just passed
    task automatic step(input bit want, input bit obey, input logic [W-1:0] ival,
                        input bit rdy, input bit spur, input logic [W-1:0] sval,
                        output bit did);
        pipe_t fr;
        int    infl;
        @(posedge clk);
        #1;
        if (prev_rv && exp_q.size() < DEPTH) exp_q.push_back(prev_r);
        m_err    = m_err | pend_err;
        pend_err = '0;
        infl     = pipe_busy();
        model_up = (exp_q.size() + infl) < DEPTH;
        did      = want && (!obey || model_up);
        fr       = pipe.pop_front();
        if (did && !model_up) pend_err[0] = 1'b1;
        if (spur && infl == 0 && !did) pend_err[1] = 1'b1;
        pipe.push_back('{vld: did, d: ival});
        issue_vld = did;
        res_vld   = fr.vld | spur;
        res       = spur ? sval : fr.d;
        out_rdy   = rdy;
        prev_rv   = fr.vld | spur;
        prev_r    = spur ? sval : fr.d;
    endtask

    task automatic idle(input bit rdy);
        bit d;
        step(1'b0, 1'b0, '0, rdy, 1'b0, '0, d);
    endtask

    task automatic drain();
        int c = 0;
        while ((exp_q.size() != 0 || pipe_busy() != 0 || prev_rv) && c < 100) begin
            idle(1'b1);
            c++;
        end
        idle(1'b1);
        idle(1'b0);
        chk("drain_done", W'(c < 100), W'(1));
        chk("drained_count", W'(count), W'(0));
    endtask

    // Pipe and buffer are reset together, so the model pipe is emptied too
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        chk_en    = 1'b0;
        issue_vld = 1'b0;
        res_vld   = 1'b0;
        out_rdy   = 1'b0;
        exp_q.delete();
        pipe.delete();
        for (int i = 0; i < int'(L); i++) pipe.push_back('{vld: 1'b0, d: '0});
        m_err    = '0;
        pend_err = '0;
        prev_rv  = 1'b0;
        model_up = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_out_vld", W'(out_vld), W'(0));
        chk("rst_count", W'(count), W'(0));
        chk("rst_up_rdy", W'(up_rdy), W'(1));
        chk("rst_err", W'(err), W'(0));
        chk_en = 1'b1;
    endtask

    initial begin
        bit         d;
        logic [W-1:0] v;
        int         c;

        do_reset();

        // Single result: visible exactly one cycle after res_vld
        step(1'b1, 1'b1, W'(7), 1'b0, 1'b0, '0, d);
        repeat (L) idle(1'b0);
        chk("single_not_yet", W'(out_vld), W'(0));
        idle(1'b0);
        chk("single_vld", W'(out_vld), W'(1));
        chk("single_data", out_data, W'(7));
        drain();

        // Credit exhaustion with a stalled consumer
        v = W'(1);
        repeat (DEPTH + L + 2) begin
            step(1'b1, 1'b1, v, 1'b0, 1'b0, '0, d);
            if (d) v = v + W'(1);
        end
        chk("credit_issued", v, W'(9));
        chk("credit_up_rdy", W'(up_rdy), W'(0));
        chk("credit_count", W'(count), W'(DEPTH));
        chk("credit_head", out_data, W'(1));
        drain();

        // Wrap-around with a toggling consumer
        v = W'(100);
        c = 0;
        while (v < W'(120) && c < 300) begin
            step(1'b1, 1'b1, v, (c % 2) == 0, 1'b0, '0, d);
            if (d) v = v + W'(1);
            c++;
        end
        chk("wrap_issued", v, W'(120));
        drain();

        // Full FIFO: credit breach result arrives while the head is popped
        v = W'(201);
        repeat (DEPTH + L + 2) begin
            step(1'b1, 1'b1, v, 1'b0, 1'b0, '0, d);
            if (d) v = v + W'(1);
        end
        step(1'b1, 1'b0, W'(555), 1'b0, 1'b0, '0, d);
        repeat (L - 1) idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        chk("full_pushpop_count", W'(count), W'(DEPTH));
        chk("full_pushpop_head", out_data, W'(202));
        chk("credit_err", W'(err[ERR_CREDIT]), W'(1));
        // Breach result with no pop is dropped
        step(1'b1, 1'b0, W'(666), 1'b0, 1'b0, '0, d);
        repeat (L + 1) idle(1'b0);
        chk("full_drop_count", W'(count), W'(DEPTH));
        drain();

        // Spurious result with nothing in flight
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, W'(999), d);
        repeat (3) idle(1'b0);
        chk("err_sticky", W'(err), W'(3));
        drain();
        chk("err_still_sticky", W'(err), W'(3));

        // Random traffic
        repeat (400) begin
            step(($urandom % 2) == 0, 1'b1, $urandom, ($urandom % 4) != 0, 1'b0, '0, d);
        end

        // Reset in the middle of traffic clears everything
        repeat (20) begin
            step(1'b1, 1'b1, $urandom, 1'b0, 1'b0, '0, d);
        end
        do_reset();

        repeat (200) begin
            step(($urandom % 3) != 0, 1'b1, $urandom, ($urandom % 3) == 0, 1'b0, '0, d);
        end
        drain();
        chk("final_err", W'(err), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_formula_1_res_buffer
